// File: rtl/hdmi_rom_pic_ctrl.sv
// Image ROM read sequencer: overlays a ROM picture at a fixed window of the HDMI timing stream.
// Optional macro PIC_BORDER_EN draws a one-pixel white frame around the picture window.
module hdmi_rom_pic_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 24,
  parameter int unsigned           IMG_W      = 256,
  parameter int unsigned           IMG_H      = 256,
  parameter int unsigned           POS_X      = 512,
  parameter int unsigned           POS_Y      = 232,
  parameter int unsigned           RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] BG_COLOR   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pic_en,
  input  logic                  vs_in,
  input  logic                  hs_in,
  input  logic                  de_in,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_rd_en,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  vs_out,
  output logic                  hs_out,
  output logic                  de_out,
  output logic [DATA_WIDTH-1:0] rgb_out,
  output logic                  frame_done,
  output logic                  cnt_err
);

  localparam int unsigned LAT   = RD_LATENCY + 2;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned X_END = POS_X + IMG_W;
  localparam int unsigned Y_END = POS_Y + IMG_H;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(IMG_W * IMG_H - 1);

  logic                  vs_q;
  logic                  de_q;
  logic                  frame_en_q;
  logic [CNT_W-1:0]      x_cnt;
  logic [CNT_W-1:0]      y_cnt;
  logic [ADDR_WIDTH-1:0] addr_cnt;

  logic frame_start;
  logic de_fall;
  logic x_in;
  logic y_in;
  logic in_win;
  logic border;

  logic [LAT-1:0] vs_sr;
  logic [LAT-1:0] hs_sr;
  logic [LAT-1:0] de_sr;
  logic [LAT-2:0] win_sr;
  logic [LAT-2:0] brd_sr;

  always_comb begin
    frame_start = vs_in & ~vs_q;
    de_fall     = de_q & ~de_in;
    x_in        = (32'(x_cnt) >= POS_X) && (32'(x_cnt) < X_END);
    y_in        = (32'(y_cnt) >= POS_Y) && (32'(y_cnt) < Y_END);
    in_win      = de_in & frame_en_q & x_in & y_in;
  end

`ifdef PIC_BORDER_EN
  logic x_edge;
  logic y_edge;
  logic x_span;
  logic y_span;

  // Edge tests use +1 on the counter so a window at column/line 0 cannot underflow.
  always_comb begin
    x_edge = (32'(x_cnt) + 32'd1 == POS_X) || (32'(x_cnt) == X_END);
    y_edge = (32'(y_cnt) + 32'd1 == POS_Y) || (32'(y_cnt) == Y_END);
    x_span = (32'(x_cnt) + 32'd1 >= POS_X) && (32'(x_cnt) <= X_END);
    y_span = (32'(y_cnt) + 32'd1 >= POS_Y) && (32'(y_cnt) <= Y_END);
    border = de_in & frame_en_q & ((x_edge & y_span) | (y_edge & x_span));
  end
`else
  always_comb begin
    border = 1'b0;
  end
`endif

  // Position tracking and frame bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q       <= 1'b0;
      de_q       <= 1'b0;
      frame_en_q <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      addr_cnt   <= '0;
      cnt_err    <= 1'b0;
    end else begin
      vs_q <= vs_in;
      de_q <= de_in;
      if (frame_start) begin
        x_cnt      <= '0;
        y_cnt      <= '0;
        addr_cnt   <= '0;
        frame_en_q <= pic_en;
        if (frame_en_q && (addr_cnt != '0)) begin
          cnt_err <= 1'b1;
        end
      end else begin
        if (de_in) begin
          if (x_cnt != '1) begin
            x_cnt <= x_cnt + 1'b1;
          end
        end else if (de_fall) begin
          x_cnt <= '0;
          if (y_cnt != '1) begin
            y_cnt <= y_cnt + 1'b1;
          end
        end
        if (in_win) begin
          addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + 1'b1;
        end
      end
    end
  end

  // ROM request register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr   <= '0;
      rom_rd_en  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rom_rd_en  <= in_win;
      frame_done <= in_win && (addr_cnt == ADDR_LAST);
      if (in_win) begin
        rom_addr <= addr_cnt;
      end
    end
  end

  // Timing and window flags travel alongside the ROM read so rgb_out lines up with de_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sr   <= '0;
      hs_sr   <= '0;
      de_sr   <= '0;
      win_sr  <= '0;
      brd_sr  <= '0;
      rgb_out <= BG_COLOR;
    end else begin
      vs_sr  <= {vs_sr[LAT-2:0], vs_in};
      hs_sr  <= {hs_sr[LAT-2:0], hs_in};
      de_sr  <= {de_sr[LAT-2:0], de_in};
      win_sr <= {win_sr[LAT-3:0], in_win};
      brd_sr <= {brd_sr[LAT-3:0], border};
      if (win_sr[LAT-2] && de_sr[LAT-2]) begin
        rgb_out <= rom_data;
      end else if (brd_sr[LAT-2] && de_sr[LAT-2]) begin
        rgb_out <= '1;
      end else begin
        rgb_out <= BG_COLOR;
      end
    end
  end

  assign vs_out = vs_sr[LAT-1];
  assign hs_out = hs_sr[LAT-1];
  assign de_out = de_sr[LAT-1];

endmodule

// File: doc/hdmi_rom_pic_ctrl.md
Name: hdmi_rom_pic_ctrl

Overview:
Sequences reads of the single-port image ROM (16-bit address, 24-bit RGB888, synchronous read) against the HDMI video timing stream. Tracks pixel position from de/vs, issues ROM addresses one pipeline stage ahead so that ROM data lines up with delayed timing, and places the picture at a fixed window over a background colour. Sits between the video timing generator and the HDMI/DVI encoder.

Parameters:
ADDR_WIDTH, 16, ROM address width
DATA_WIDTH, 24, ROM/pixel data width (RGB888)
IMG_W, 256, picture width in pixels
IMG_H, 256, picture height in lines (IMG_W*IMG_H <= 2**ADDR_WIDTH)
POS_X, 512, first active pixel column of the window
POS_Y, 232, first active line of the window
RD_LATENCY, 1, ROM address-to-data latency in clocks (1 = no output reg, 2 = output reg)
BG_COLOR, 24'h000000, pixel value outside the window or when disabled

Ports:
clk  in  1  pixel clock; drives ROM clk as well
rst_n  in  1  asynchronous active-low reset
pic_en  in  1  picture enable; sampled at frame start only
vs_in  in  1  vertical sync, active high
hs_in  in  1  horizontal sync, active high
de_in  in  1  data enable, active video
rom_addr  out  ADDR_WIDTH  ROM read address (registered)
rom_rd_en  out  1  high in cycles where rom_addr is a valid read
rom_data  in  DATA_WIDTH  ROM read data
vs_out  out  1  vs_in delayed by LAT
hs_out  out  1  hs_in delayed by LAT
de_out  out  1  de_in delayed by LAT
rgb_out  out  DATA_WIDTH  pixel data aligned with de_out
frame_done  out  1  one-clock pulse when the last picture pixel is read
cnt_err  out  1  sticky: a frame ended with an incomplete picture read

Behaviour:
- All outputs reset to 0 (rgb_out = BG_COLOR); counters, frame_en_q and delay lines cleared.
- LAT = RD_LATENCY + 2 clocks: input sample, address register, RD_LATENCY ROM cycles, output register.
- Frame start = rising edge of vs_in (registered edge detect). At frame start: y_cnt <= 0, x_cnt <= 0, addr_cnt <= 0, frame_en_q <= pic_en. Changes to pic_en mid-frame have no effect until the next frame start.
- x_cnt: increments on each de_in-high cycle and clears on the de_in falling edge. y_cnt: increments on each de_in falling edge. Both counters saturate at all-ones and do not wrap.
- in_win = de_in & frame_en_q & (POS_X <= x_cnt < POS_X+IMG_W) & (POS_Y <= y_cnt < POS_Y+IMG_H).
- When in_win is high in cycle T, rom_addr <= addr_cnt, rom_rd_en <= 1 at the T edge, and addr_cnt increments. When in_win is low, rom_rd_en <= 0 and rom_addr holds its value.
- When addr_cnt == IMG_W*IMG_H-1 and in_win: frame_done pulses with that rom_rd_en, and addr_cnt wraps to 0.
- Window-valid flag in_win is pipelined LAT-1 stages. At output, rgb_out <= (win_dly & de_dly) ? rom_data : BG_COLOR. de/hs/vs are delayed exactly LAT, so the first window pixel appears on rgb_out LAT clocks after its de_in cycle.
- cnt_err: set at frame start if the previous frame had frame_en_q=1 and addr_cnt != 0 (picture cut off because the window exceeds the active area). It is cleared only by rst_n.
- Frame with frame_en_q=0: no reads, rgb_out = BG_COLOR throughout, and cnt_err is not evaluated.
- Reset asserted mid-frame: everything clears immediately. After release, no reads occur until the next vs_in rising edge.

Optional Feature:
Macro PIC_BORDER_EN.
- Defined: pixels one column or one line outside the window (x = POS_X-1, x = POS_X+IMG_W, y = POS_Y-1, y = POS_Y+IMG_H, within their span) output 24'hFFFFFF. These pixels cause no ROM read, and their latency and alignment are unchanged.
- Undefined: those pixels output BG_COLOR.

Test Plan:
- 720p timing, pic_en=1, RD_LATENCY=1, ROM model data=address: first window pixel (x=512, y=232) gives rgb_out=24'h000000 on de_out 3 clocks after its de_in; the next pixel is 24'h000001; line 233, x=512 gives 24'h000100; exactly 65536 rom_rd_en cycles per frame; frame_done pulses once with rom_addr=16'hFFFF.
- pic_en dropped mid-frame: current frame completes normally; next frame has rom_rd_en never high and rgb_out=BG_COLOR; pic_en raised mid-frame takes effect only from the following frame.
- POS_Y=600 (window overruns 720 lines): at the next vs rising edge cnt_err=1, and it stays 1 over later frames until rst_n is pulsed.
- RD_LATENCY=2 with a registered ROM model: LAT=4; de_out/hs_out/vs_out equal the inputs delayed by 4, and rgb_out data remains address-correct.
- rst_n low for 5 clocks at line 300: all outputs 0 and rgb_out=BG_COLOR asynchronously; no rom_rd_en until the next vs rising edge, then a full frame of 65536 reads.
- PIC_BORDER_EN defined: x=511 and x=768 on lines 232..487, and lines 231/488 for x=511..768, give 24'hFFFFFF; rom_rd_en count is still 65536.
